// File: rtl/blood_monitor_pkg.sv
// Shared state encoding and widths for the blood alarm controller.
package blood_monitor_pkg;
    localparam int STATE_W = 2;
    localparam int STATS_W = 8;

    typedef enum logic [STATE_W-1:0] {
        NORMAL   = 2'd0,
        SUSPECT  = 2'd1,
        ALARM    = 2'd2,
        SILENCED = 2'd3
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;
endmodule

// File: rtl/blood_alarm_controller.sv
// Confirms persistent blood abnormality, raises and latches a nurse alarm.
// Optional BLOOD_ALARM_STATS_EN adds a saturating alarm-entry counter output.
module blood_alarm_controller
    import blood_monitor_pkg::*;
#(
    parameter int CONFIRM_COUNT = 3,
    parameter int CLEAR_COUNT   = 4,
    parameter int CNT_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sampleValid,
    input  logic               bloodAbnormality,
    input  logic               alarmAck,
    output logic               alarm,
    output logic               alarmPulse,
    output logic               alarmActive,
    output logic [CNT_W-1:0]   abnormalStreak,
`ifdef BLOOD_ALARM_STATS_EN
    output logic [STATS_W-1:0] alarmEventCount,
`endif
    output logic [STATE_W-1:0] monitorState
);
    localparam logic [CNT_W-1:0] CONF_TH  = CNT_W'(CONFIRM_COUNT);
    localparam logic [CNT_W-1:0] CLEAR_TH = CNT_W'(CLEAR_COUNT);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_alarm, r_pulse, r_active;
    logic             w_abn, w_nrm;
    logic [CNT_W-1:0] w_clr_streak;
    logic [CNT_W-1:0] w_abn_nxt, w_clr_nxt;
    logic             w_conf_hit, w_clear_hit, w_enter_alarm;

    assign w_abn = sampleValid &  bloodAbnormality;
    assign w_nrm = sampleValid & ~bloodAbnormality;

    sat_counter #(.WIDTH(CNT_W)) u_abn_streak (
        .clk(clk), .rst(rst), .inc(w_abn), .clr(w_nrm), .count(abnormalStreak)
    );

    sat_counter #(.WIDTH(CNT_W)) u_clr_streak (
        .clk(clk), .rst(rst), .inc(w_nrm), .clr(w_abn), .count(w_clr_streak)
    );

    // Thresholds are judged on the value the counter will hold after this sample.
    assign w_abn_nxt   = (abnormalStreak == {CNT_W{1'b1}}) ? abnormalStreak : abnormalStreak + 1'b1;
    assign w_clr_nxt   = (w_clr_streak   == {CNT_W{1'b1}}) ? w_clr_streak   : w_clr_streak + 1'b1;
    assign w_conf_hit  = (w_abn_nxt >= CONF_TH);
    assign w_clear_hit = (w_clr_nxt >= CLEAR_TH);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            NORMAL:   if (w_abn) w_nxt = w_conf_hit ? ALARM : SUSPECT;
            SUSPECT:  if (w_abn && w_conf_hit) w_nxt = ALARM;
                      else if (w_nrm)          w_nxt = NORMAL;
            // Clearing beats a simultaneous acknowledge.
            ALARM:    if (w_nrm && w_clear_hit) w_nxt = NORMAL;
                      else if (alarmAck)        w_nxt = SILENCED;
            SILENCED: if (w_nrm && w_clear_hit) w_nxt = NORMAL;
            default:  w_nxt = NORMAL;
        endcase
    end

    assign w_enter_alarm = (w_nxt == ALARM) && (r_state != ALARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= NORMAL;
            r_alarm  <= 1'b0;
            r_pulse  <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_alarm  <= (w_nxt == ALARM);
            r_pulse  <= w_enter_alarm;
            r_active <= (w_nxt == ALARM) || (w_nxt == SILENCED);
        end
    end

`ifdef BLOOD_ALARM_STATS_EN
    sat_counter #(.WIDTH(STATS_W)) u_evt_cnt (
        .clk(clk), .rst(rst), .inc(w_enter_alarm), .clr(1'b0), .count(alarmEventCount)
    );
`endif

    assign alarm        = r_alarm;
    assign alarmPulse   = r_pulse;
    assign alarmActive  = r_active;
    assign monitorState = r_state;
endmodule

// File: tb/tb_blood_alarm_controller.sv
// Directed self-checking bench for blood_alarm_controller (CONFIRM=3, CLEAR=4).
module tb_blood_alarm_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sampleValid = 1'b0;
    logic       bloodAbnormality = 1'b0;
    logic       alarmAck = 1'b0;
    logic       alarm, alarmPulse, alarmActive;
    logic [3:0] abnormalStreak;
    logic [1:0] monitorState;
`ifdef BLOOD_ALARM_STATS_EN
    logic [7:0] alarmEventCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blood_alarm_controller #(.CONFIRM_COUNT(3), .CLEAR_COUNT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sampleValid(sampleValid),
        .bloodAbnormality(bloodAbnormality), .alarmAck(alarmAck),
        .alarm(alarm), .alarmPulse(alarmPulse), .alarmActive(alarmActive),
        .abnormalStreak(abnormalStreak),
`ifdef BLOOD_ALARM_STATS_EN
        .alarmEventCount(alarmEventCount),
`endif
        .monitorState(monitorState)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; outputs are sampled 1ns after the capturing edge.
    task automatic step(input logic v, input logic a, input logic k);
        @(negedge clk);
        sampleValid = v; bloodAbnormality = a; alarmAck = k;
        @(posedge clk);
        #1;
        sampleValid = 1'b0; bloodAbnormality = 1'b0; alarmAck = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic al,
                           input logic pu, input logic ac);
        chk({tag, ".state"},  32'(monitorState), 32'(st));
        chk({tag, ".alarm"},  32'(alarm),        32'(al));
        chk({tag, ".pulse"},  32'(alarmPulse),   32'(pu));
        chk({tag, ".active"}, 32'(alarmActive),  32'(ac));
    endtask

    initial begin
        #12;
        chk_out("reset", 2'd0, 0, 0, 0);
        chk("reset.streak", 32'(abnormalStreak), 32'd0);
`ifdef BLOOD_ALARM_STATS_EN
        chk("reset.evt", 32'(alarmEventCount), 32'd0);
`endif
        @(negedge clk); rst = 1'b0;

        // 1: confirm after three abnormal samples
        step(1, 1, 0); chk_out("t1.s1", 2'd1, 0, 0, 0); chk("t1.k1", 32'(abnormalStreak), 32'd1);
        step(0, 1, 0); chk_out("t1.hold", 2'd1, 0, 0, 0); chk("t1.khold", 32'(abnormalStreak), 32'd1);
        step(1, 1, 0); chk_out("t1.s2", 2'd1, 0, 0, 0); chk("t1.k2", 32'(abnormalStreak), 32'd2);
        step(1, 1, 0); chk_out("t1.s3", 2'd2, 1, 1, 1); chk("t1.k3", 32'(abnormalStreak), 32'd3);
`ifdef BLOOD_ALARM_STATS_EN
        chk("t1.evt", 32'(alarmEventCount), 32'd1);
`endif
        step(0, 0, 0); chk_out("t1.idle", 2'd2, 1, 0, 1);
        step(1, 1, 0); chk_out("t1.abn", 2'd2, 1, 0, 1);

        // 3: acknowledge then clear from SILENCED, abnormal resets clear run without re-alarm
        step(0, 0, 1); chk_out("t3.ack", 2'd3, 0, 0, 1);
        step(1, 0, 0); chk_out("t3.n1", 2'd3, 0, 0, 1); chk("t3.k", 32'(abnormalStreak), 32'd0);
        step(1, 0, 0); step(1, 1, 0); chk_out("t3.reabn", 2'd3, 0, 0, 1);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); chk_out("t3.n3", 2'd3, 0, 0, 1);
        step(1, 0, 0); chk_out("t3.n4", 2'd0, 0, 0, 0);

        // ack outside ALARM ignored
        step(0, 0, 1); chk_out("ack_idle", 2'd0, 0, 0, 0);

        // 2: interrupted streak never alarms
        step(1, 1, 0); chk("t2.k1", 32'(abnormalStreak), 32'd1); chk("t2.st1", 32'(monitorState), 32'd1);
        step(1, 1, 0); chk("t2.k2", 32'(abnormalStreak), 32'd2);
        step(1, 0, 0); chk("t2.k3", 32'(abnormalStreak), 32'd0); chk("t2.st3", 32'(monitorState), 32'd0);
        step(1, 1, 0); chk("t2.k4", 32'(abnormalStreak), 32'd1);
        step(1, 1, 0); chk("t2.k5", 32'(abnormalStreak), 32'd2); chk_out("t2.end", 2'd1, 0, 0, 0);
        step(1, 0, 0); chk("t2.back", 32'(monitorState), 32'd0);

        // 4: clear beats simultaneous ack
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); chk_out("t4.alarm", 2'd2, 1, 1, 1);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); chk_out("t4.n3", 2'd2, 1, 0, 1);
        step(1, 0, 1); chk_out("t4.n4ack", 2'd0, 0, 0, 0);

        // 5: async reset mid-alarm
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); chk_out("t5.alarm", 2'd2, 1, 1, 1);
        @(negedge clk); #2; rst = 1'b1; #1;
        chk_out("t5.async", 2'd0, 0, 0, 0);
        chk("t5.kasync", 32'(abnormalStreak), 32'd0);
        @(negedge clk); rst = 1'b0;
        step(0, 0, 0); chk("t5.k", 32'(abnormalStreak), 32'd0); chk_out("t5.after", 2'd0, 0, 0, 0);

`ifdef BLOOD_ALARM_STATS_EN
        // 6: event counter saturates
        chk("t6.evt0", 32'(alarmEventCount), 32'd0);
        for (int n = 0; n < 300; n++) begin
            step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
            step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
            if (n == 9) chk("t6.evt10", 32'(alarmEventCount), 32'd10);
        end
        chk("t6.evtsat", 32'(alarmEventCount), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
